// File: rtl/mem_miss_arbiter.sv
// mem_miss_arbiter: shares one main memory between I-cache fills, D-cache fills and D-cache stores.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates I/D fill grants under contention (stores always first).
module mem_miss_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = 8,
   parameter int MEM_LAT     = 4,
   localparam int OW         = $clog2(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [OW-1:0]     fill_offset,
   output logic              i_fill_we,
   output logic              d_fill_we,
   output logic              i_done,
   output logic              d_done,
   output logic              busy
);
   if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_cfg_err
      $error("mem_miss_arbiter: BLOCK_WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
   end
   typedef enum logic [2:0] {IDLE, STORE, ISSUE, DRAIN, DONE} state_t;
   localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [OW-1:0]     issue_q, issue_d;
   logic [OW:0]       ret_q, ret_d;
   logic              acc, fill_i, fill_d, grant_i;
   assign fill_i = i_req;
   assign fill_d = d_req & ~d_wr;
   // owner_q: 0 = I-cache, 1 = D-cache
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   assign grant_i = fill_i & (~fill_d | last_q);
`else
   assign grant_i = fill_i;
`endif
   assign acc = mem_valid & (state_q == ISSUE || state_q == DRAIN) & ~ret_q[OW];
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      base_d  = base_q;
      issue_d = issue_q;
      ret_d   = ret_q + (OW + 1)'(acc);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            ret_d = '0;
            if (d_req & d_wr) begin
               state_d = STORE;
               owner_d = 1'b1;
            end else if (fill_i | fill_d) begin
               state_d = ISSUE;
               owner_d = ~grant_i;
               base_d  = (grant_i ? i_addr : d_addr) & MASK;
               issue_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_d  = ~grant_i;
`endif
            end
         end
         STORE: state_d = DONE;
         ISSUE: begin
            issue_d = issue_q + 1'b1;
            state_d = ret_d[OW] ? DONE : (issue_q == OW'(BLOCK_WORDS - 1)) ? DRAIN : ISSUE;
         end
         DRAIN: state_d = ret_d[OW] ? DONE : DRAIN;
         DONE: begin
            state_d = IDLE;
            issue_d = '0;
            ret_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         base_q  <= '0;
         issue_q <= '0;
         ret_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         base_q  <= base_d;
         issue_q <= issue_d;
         ret_q   <= ret_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end
   // Memory strobes decode from registered state; fills pass returning data straight through.
   assign mem_en      = state_q == STORE || state_q == ISSUE;
   assign mem_wr      = state_q == STORE;
   assign mem_addr    = state_q == STORE ? d_addr :
                        state_q == ISSUE ? base_q + ADDR_W'({issue_q, 1'b0}) : '0;
   assign mem_wdata   = state_q == STORE ? d_wdata : '0;
   assign fill_data   = acc ? mem_rdata : '0;
   assign fill_offset = acc ? ret_q[OW-1:0] : '0;
   assign i_fill_we   = acc & ~owner_q;
   assign d_fill_we   = acc & owner_q;
   assign i_done      = state_q == DONE && !owner_q;
   assign d_done      = state_q == DONE && owner_q;
   assign busy        = state_q != IDLE;
endmodule

// File: doc/mem_miss_arbiter.md
Name: mem_miss_arbiter

Overview:
- Sequences the shared 4-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between both caches and the main memory.
- On a granted miss, issues BLOCK_WORDS sequential word reads, counts the returning data, and streams each word back to the winning cache with its block offset.
- Pulses done when the block is filled. The pipeline stall holds until done.

Parameters:
- ADDR_W, 16, address width (byte addresses, 16-bit words).
- DATA_W, 16, data word width.
- BLOCK_WORDS, 8, words per cache block (power of 2).
- MEM_LAT, 4, fixed main-memory read latency in cycles (informational; completion is tracked via mem_valid).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache miss pending (level).
- i_addr  in  ADDR_W  I-cache missed address.
- d_req  in  1  D-cache request pending (level): miss fill or store.
- d_wr  in  1  with d_req: store request, no fill.
- d_addr  in  ADDR_W  D-cache address.
- d_wdata  in  DATA_W  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_valid  in  1  mem_rdata valid.
- fill_data  out  DATA_W  word being written into the cache.
- fill_offset  out  log2(BLOCK_WORDS)  word index within the block.
- i_fill_we  out  1  write fill_data into the I-cache.
- d_fill_we  out  1  write fill_data into the D-cache.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_done  out  1  one-cycle pulse: D fill or store complete.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, issue and return counters=0, all outputs 0.
- States: IDLE, STORE, ISSUE, DRAIN, DONE.
- IDLE, priority at the sampling edge: (1) d_req&d_wr, go to STORE; (2) i_req, grant I, go to ISSUE; (3) d_req&~d_wr, grant D, go to ISSUE.
- Grant latches owner and base = addr with the low log2(BLOCK_WORDS*2) bits cleared.
- STORE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata. Then DONE with d_done.
- ISSUE, cycle k (k=0..BLOCK_WORDS-1): mem_en=1, mem_wr=0, mem_addr=base+2k.
  - The first issue is the cycle after the grant edge.
  - After k=BLOCK_WORDS-1, go to DRAIN.
- Returns, counted in ISSUE and DRAIN: each mem_valid=1 cycle gives fill_data=mem_rdata, fill_offset=return count, and the owner's fill_we=1 in that same cycle (combinational pass-through).
  - The return count increments on each mem_valid.
  - When the count reaches BLOCK_WORDS, go to DONE.
  - A return may arrive during ISSUE; it is accepted.
- DONE: one cycle. The owner's done=1, counters clear, go to IDLE.
  - A new request can be granted at the edge ending DONE+IDLE, so there are at least 2 cycles between consecutive grants.
- Owner and base stay frozen for the whole transaction. Dropping i_req or d_req mid-fill does not abort it.
- mem_valid in IDLE, STORE or DONE, or beyond BLOCK_WORDS returns: ignored, with no fill_we.
- Simultaneous i_req and d_req (fill): I wins under fixed priority. The loser stays pending and is granted after DONE.
- Reset mid-operation: immediate return to IDLE. Late mem_valid after reset is ignored.
- mem_wr is never high in ISSUE or DRAIN. i_fill_we and d_fill_we are never high together.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register (reset = D) arbitrates between I and D fills.
  - When both request fills, the requester that was not the last fill owner wins.
  - Stores keep top priority and do not update last_owner.
- Undefined: fixed priority, I over D fill. The last_owner register is absent.

Test Plan:
- I miss only: i_req=1, i_addr=0x0136.
  - Required: mem_addr=0x0130,0x0132,…,0x013E on 8 consecutive cycles starting one cycle after the grant.
  - 8 mem_valid pulses give i_fill_we with offsets 0..7 and fill_data matching mem_rdata.
  - i_done pulses once; d_fill_we stays 0.
- D store: d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0xBEEF.
  - Required: exactly one cycle of mem_en=mem_wr=1 at 0x0200 with 0xBEEF, then d_done.
  - busy is high for 2 cycles.
- Contention: i_req=1 and d_req=1 (d_wr=0) on the same edge.
  - Required: the I fill completes first (i_done), then the D fill with d_done.
  - With MEM_ARB_ROUND_ROBIN_EN after reset: I first; on a repeat contention, D first.
- Contention with store: i_req=1, d_req=1, d_wr=1 together.
  - Required: the store issues first, then the I fill.
- Reset mid-fill: assert rst=0 after 3 returns.
  - Required: all outputs 0 asynchronously.
  - After release, stale mem_valid pulses produce no fill_we; busy=0.
- Spurious mem_valid in IDLE, and a requester dropping mid-fill.
  - Required: no fill_we in IDLE.
  - A fill whose i_req drops after the grant still issues all 8 reads and pulses i_done.
